// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package reg_file_wr_arbiter_pkg;

    localparam int unsigned BurstCntW = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reg_file_wr_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot choice among valid requesters, tie goes to
// the requester that did not own the port last.
module reg_file_wr_arbiter_rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_owner,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (valid0 && valid1) begin
            pick = last_owner ? 2'b01 : 2'b10;
        end else if (valid0) begin
            pick = 2'b01;
        end else if (valid1) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin owner of the register file's single write port, shared by two
// valid/ready requesters with a bounded burst per ownership.
module reg_file_wr_arbiter
    import reg_file_wr_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 1,
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wen_out,
    output logic [ADDR_W-1:0] waddr_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic [1:0]        owner_out
);

    localparam logic [BurstCntW-1:0] BurstLimit = BurstCntW'(MAX_BURST);

    arb_state_e           state_q;
    logic                 last_owner_q;
    logic [BurstCntW-1:0] burst_cnt_q;
    logic [BurstCntW-1:0] burst_inc;
    logic [1:0]           pick;

    // Current owner's request and the contender, folded so both grant states share one path.
    logic              own_is1;
    logic              own_valid;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;
    logic              other_valid;
    arb_state_e        other_state;
    logic              other_id;

    reg_file_wr_arbiter_rr_pick2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    always_comb begin
        own_is1     = (state_q == StGrant1);
        own_valid   = own_is1 ? req1_valid : req0_valid;
        own_addr    = own_is1 ? req1_addr  : req0_addr;
        own_data    = own_is1 ? req1_data  : req0_data;
        other_valid = own_is1 ? req0_valid : req1_valid;
        other_state = own_is1 ? StGrant0   : StGrant1;
        other_id    = ~own_is1;
        burst_inc   = burst_cnt_q + 4'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            wen_out      <= 1'b0;
            waddr_out    <= '0;
            wdata_out    <= '0;
        end else begin
            wen_out <= 1'b0;
            case (state_q)
                StIdle: begin
                    burst_cnt_q <= '0;
                    if (pick[0]) begin
                        state_q      <= StGrant0;
                        last_owner_q <= 1'b0;
                    end else if (pick[1]) begin
                        state_q      <= StGrant1;
                        last_owner_q <= 1'b1;
                    end
                end
                StGrant0, StGrant1: begin
                    if (own_valid) begin
                        wen_out   <= 1'b1;
                        waddr_out <= own_addr;
                        wdata_out <= own_data;
                        if (burst_inc == BurstLimit) begin
                            burst_cnt_q <= '0;
                            if (other_valid) begin
                                state_q      <= other_state;
                                last_owner_q <= other_id;
                            end
                        end else begin
                            burst_cnt_q <= burst_inc;
                        end
                    end else begin
                        burst_cnt_q <= '0;
                        if (other_valid) begin
                            state_q      <= other_state;
                            last_owner_q <= other_id;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req0_ready = (state_q == StGrant0);
    assign req1_ready = (state_q == StGrant1);
    assign owner_out  = {req1_ready, req0_ready};

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Self-checking bench for reg_file_wr_arbiter against a cycle-level reference model.
module tb_reg_file_wr_arbiter;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;
    localparam int OW = 5 + AW + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, wen_out;
    logic [AW-1:0] waddr_out;
    logic [DW-1:0] wdata_out;
    logic [1:0]    owner_out;

    int errors = 0;
    int checks = 0;

    // Reference model: owner -1 means idle.
    int            m_owner, m_last, m_cnt;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    logic [DW-1:0] rf [2**AW];

    always #5 clock = ~clock;

    reg_file_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wen_out    (wen_out),
        .waddr_out  (waddr_out),
        .wdata_out  (wdata_out),
        .owner_out  (owner_out)
    );

    always @(posedge clock) if (wen_out) rf[waddr_out] <= wdata_out;

    wire [OW-1:0] obs = {req1_ready, req0_ready, owner_out, wen_out, waddr_out, wdata_out};

    function automatic logic [OW-1:0] model_obs();
        logic r0, r1;
        r0 = (m_owner == 0);
        r1 = (m_owner == 1);
        return {r1, r0, r1, r0, m_wen, m_waddr, m_wdata};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic model_step();
        bit            v [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int o, x;
        v[0] = req0_valid; a[0] = req0_addr; d[0] = req0_data;
        v[1] = req1_valid; a[1] = req1_addr; d[1] = req1_data;
        if (m_owner < 0) begin
            m_wen = 1'b0;
            if (v[0] && v[1]) m_owner = 1 - m_last;
            else if (v[0]) m_owner = 0;
            else if (v[1]) m_owner = 1;
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else begin
            o = m_owner;
            x = 1 - o;
            if (v[o]) begin
                m_wen   = 1'b1;
                m_waddr = a[o];
                m_wdata = d[o];
                m_cnt++;
                if (m_cnt == MB) begin
                    m_cnt = 0;
                    if (v[x]) begin
                        m_owner = x;
                        m_last  = x;
                    end
                end
            end else begin
                m_wen   = 1'b0;
                m_cnt   = 0;
                m_owner = v[x] ? x : -1;
                if (v[x]) m_last = x;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        checks++;
        if (obs !== {OW{1'b0}}) begin
            errors++;
            $display("FAIL reset_async obs=%h exp=%h", obs, {OW{1'b0}});
        end
        tick();
        tick();
        @(negedge clock);
        checks++;
        if (obs !== {OW{1'b0}}) begin
            errors++;
            $display("FAIL reset_held obs=%h exp=%h", obs, {OW{1'b0}});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        tick();
        req0_valid = 1'b1;
        req0_addr  = 3'd1;
        req0_data  = 8'd1;
        @(negedge clock);
        checks++;
        if (obs !== model_obs() || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_idle obs=%h exp=%h", obs, model_obs());
        end
        tick();
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1 || obs !== model_obs()) begin
            errors++;
            $display("FAIL single_ready ready0=%b obs=%h exp=%h", req0_ready, obs, model_obs());
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({wen_out, waddr_out, wdata_out} !== {1'b1, 3'd1, 8'd1}) begin
            errors++;
            $display("FAIL single_wen got=%b/%0d/%0d exp=1/1/1", wen_out, waddr_out, wdata_out);
        end
        tick();
        @(negedge clock);
        checks++;
        if (rf[1] !== 8'd1 || obs !== model_obs()) begin
            errors++;
            $display("FAIL single_rf rf1=%0d exp=1 obs=%h exp=%h", rf[1], obs, model_obs());
        end
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'($urandom);
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'($urandom);
        tick();
        @(negedge clock);
        checks++;
        if (owner_out !== 2'b01) begin
            errors++;
            $display("FAIL tie_first owner=%b exp=01", owner_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clock);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL tie_burst obs=%h exp=%h", obs, model_obs());
            end
        end
        req0_valid = 1'b0;
        tick();
        @(negedge clock);
        checks++;
        if (owner_out !== 2'b10 || obs !== model_obs()) begin
            errors++;
            $display("FAIL tie_handoff owner=%b exp=10 obs=%h exp=%h", owner_out, obs, model_obs());
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_burst_alternate();
        int seq [$];
        int gaps = 0;
        bit acc0, acc1;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL alt_cycle%0d obs=%h exp=%h", i, obs, model_obs());
            end
            if (i >= 2 && !wen_out) gaps++;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (acc0) begin
                seq.push_back(0);
                req0_addr = 3'($urandom); req0_data = 8'($urandom);
            end
            if (acc1) begin
                seq.push_back(1);
                req1_addr = 3'($urandom); req1_data = 8'($urandom);
            end
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL alt_wen_gaps got=%0d exp=0", gaps);
        end
        checks++;
        if (seq.size() != 33) begin
            errors++;
            $display("FAIL alt_count got=%0d exp=33", seq.size());
        end
        foreach (seq[k]) begin
            checks++;
            if (seq[k] != (k / MB) % 2) begin
                errors++;
                $display("FAIL alt_order write%0d owner=%0d exp=%0d", k, seq[k], (k / MB) % 2);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_no_contender();
        int accepted = 0, run = 0, best = 0, bad_owner = 0;
        req0_valid = 1'b1;
        req0_addr = 3'($urandom); req0_data = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL solo_cycle%0d obs=%h exp=%h", i, obs, model_obs());
            end
            if (owner_out == 2'b10) bad_owner++;
            if (i >= 1 && accepted < 10 && req0_ready !== 1'b1) bad_owner++;
            run = wen_out ? run + 1 : 0;
            if (run > best) best = run;
            if (req0_valid && req0_ready) accepted++;
            tick();
            if (accepted == 10) req0_valid = 1'b0;
            else begin
                req0_addr = 3'($urandom); req0_data = 8'($urandom);
            end
        end
        checks++;
        if (best != 10) begin
            errors++;
            $display("FAIL solo_run got=%0d exp=10", best);
        end
        checks++;
        if (bad_owner != 0) begin
            errors++;
            $display("FAIL solo_owner bad_cycles=%0d exp=0", bad_owner);
        end
    endtask

    task automatic test_reset_mid_burst();
        req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 8'hA5;
        tick();
        tick();
        tick();
        checks++;
        if (wen_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre wen=%b exp=1", wen_out);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== {OW{1'b0}}) begin
            errors++;
            $display("FAIL midrst_async obs=%h exp=%h", obs, {OW{1'b0}});
        end
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_addr = 3'd3; req1_data = 8'h3C;
        @(negedge clock);
        reset = 1'b0;
        tick();
        @(negedge clock);
        checks++;
        if (owner_out !== 2'b01 || obs !== model_obs()) begin
            errors++;
            $display("FAIL midrst_tie owner=%b exp=01 obs=%h exp=%h", owner_out, obs, model_obs());
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_drop_unready();
        int bad = 0;
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'h0A;
        req1_addr  = 3'd6; req1_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL drop_cycle%0d obs=%h exp=%h", i, obs, model_obs());
            end
            if (wen_out && wdata_out == 8'hEE) bad++;
            if (owner_out == 2'b10) bad++;
            tick();
            req0_data = req0_data + 8'd1;
            if (i == 1) req1_valid = 1'b1;
            if (i == 3) req1_valid = 1'b0;
            if (i == 8) req0_valid = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_req1_seen bad_cycles=%0d exp=0", bad);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit acc0 = 1'b0, acc1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req0_valid && !acc0) begin
                if ($urandom_range(7) == 0) req0_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(3) != 0);
                req0_addr = 3'($urandom); req0_data = 8'($urandom);
            end
            if (req1_valid && !acc1) begin
                if ($urandom_range(7) == 0) req1_valid = 1'b0;
            end else begin
                req1_valid = ($urandom_range(3) != 0);
                req1_addr = 3'($urandom); req1_data = 8'($urandom);
            end
            @(negedge clock);
            checks++;
            if (obs !== model_obs()) begin
                errors++;
                $display("FAIL rand_cycle%0d obs=%h exp=%h", i, obs, model_obs());
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_burst_alternate();
        test_no_contender();
        test_reset_mid_burst();
        test_drop_unready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
